// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU load/store port and word-wide dMem port of mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_unsigned;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic              cpu_busy;
    logic              cpu_misalign;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_done, cpu_busy, cpu_misalign, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_done, cpu_busy, cpu_misalign, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: word-only dMem load/store unit with sub-word RMW stores; MISALIGN_EXC_EN enables misalignment exceptions
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, EXC} state_t;

    state_t            state, nxt;
    logic              we_q, uns_q, mis, fin;
    logic [1:0]        size_q, lane;
    logic [4:0]        sh;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q, rdata_q, word_sh, load_val, lane_mask, merged;
    logic              done_q;

`ifdef MISALIGN_EXC_EN
    assign mis = (bus.cpu_size == 2'b01 && bus.cpu_addr[0]) ||
                 (bus.cpu_size[1] && bus.cpu_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign fin       = state inside {LOAD, STORE, RMW_WR, EXC};
    assign lane      = size_q[1] ? 2'b00 : size_q[0] ? {addr_q[1], 1'b0} : addr_q[1:0];
    assign sh        = {lane, 3'b000};
    assign word_sh   = bus.mem_rdata >> sh;
    assign load_val  = size_q[1] ? word_sh :
                       size_q[0] ? {{16{~uns_q & word_sh[15]}}, word_sh[15:0]} :
                                   {{24{~uns_q & word_sh[7]}}, word_sh[7:0]};
    assign lane_mask = size_q[0] ? 32'h0000FFFF << sh : 32'h000000FF << sh;
    assign merged    = (bus.mem_rdata & ~lane_mask) | ((data_q << sh) & lane_mask);

    assign bus.cpu_busy  = state != IDLE;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.mem_we    = state == STORE || state == RMW_WR;
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = data_q;

    // State register; reset abandons any in-flight access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state: accept only in IDLE, sub-word stores take the read-then-write path
    always_comb begin
        nxt = IDLE;
        if (state == IDLE)
            nxt = !bus.cpu_req ? IDLE : mis ? EXC : !bus.cpu_we ? LOAD :
                  bus.cpu_size[1] ? STORE : RMW_RD;
        else if (state == RMW_RD)
            nxt = RMW_WR;
    end

    // Request latch, merge buffer, load result and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (state == IDLE && bus.cpu_req) begin
                we_q   <= bus.cpu_we;
                uns_q  <= bus.cpu_unsigned;
                size_q <= bus.cpu_size;
                addr_q <= bus.cpu_addr;
                data_q <= bus.cpu_wdata;
            end
            if (state == RMW_RD) data_q <= merged;
            if (state == LOAD) rdata_q <= load_val;
        end
    end

`ifdef MISALIGN_EXC_EN
    logic mis_q;

    // Misalign flag follows each completion: set for an exception, cleared otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   mis_q <= 1'b0;
        else if (fin) mis_q <= state == EXC;
    end

    assign bus.cpu_misalign = mis_q;
`else
    assign bus.cpu_misalign = 1'b0;
`endif

    logic unused_we;
    assign unused_we = we_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl against a byte-addressed reference memory
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pre = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mbusy = 0;
    int   we_cnt = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] dmem [0:63];
    logic [7:0]  ref_b [0:255];

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        mis;
        int          wes;
        logic [31:0] maddr;
    } exp_t;
    exp_t q[$];

    mem_access_ctrl_if #(.ADDR_W(32)) bus ();

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre) begin
            for (int i = 0; i < 64; i++) dmem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
        end else if (bus.mem_we) begin
            dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            we_cnt = 0;
        end else begin
            if (bus.mem_we) we_cnt++;
            if (bus.cpu_done || (q.size() != 0 && q[0].cyc == cyc)) begin
                if (q.size() == 0) begin
                    chk("done_spurious", 32'(bus.cpu_done), 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done", 32'(bus.cpu_done), 32'h1);
                    chk("rdata", bus.cpu_rdata, e.rd);
                    chk("misalign", 32'(bus.cpu_misalign), 32'(e.mis));
                    chk("mem_we_cycles", 32'(we_cnt), 32'(e.wes));
                    chk("mem_addr", bus.mem_addr, e.maddr);
                    we_cnt = 0;
                end
            end
        end
    end

    task automatic step(input bit go, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n, ea, lat;
        logic [63:0] v;
        bit mis;
        @(negedge clk);
        chk("busy", 32'(bus.cpu_busy), 32'(mbusy != 0));
        if (mbusy != 0) begin
            mbusy--;
            bus.cpu_req      = 1'($urandom_range(1));
            bus.cpu_we       = 1'($urandom_range(1));
            bus.cpu_size     = 2'($urandom_range(3));
            bus.cpu_unsigned = 1'($urandom_range(1));
            bus.cpu_addr     = $urandom;
            bus.cpu_wdata    = $urandom;
        end else if (!go) begin
            bus.cpu_req = 1'b0;
        end else begin
            bus.cpu_req      = 1'b1;
            bus.cpu_we       = we;
            bus.cpu_size     = sz;
            bus.cpu_unsigned = uns;
            bus.cpu_addr     = a;
            bus.cpu_wdata    = wd;
            n   = sz[1] ? 4 : sz[0] ? 2 : 1;
            ea  = int'(a[7:0]) & ~(n - 1);
            mis = 1'b0;
`ifdef MISALIGN_EXC_EN
            mis = (int'(a[7:0]) % n) != 0;
`endif
            if (mis) begin
                lat = 2;
            end else if (!we) begin
                v = 64'd0;
                for (int k = 0; k < n; k++) v += 64'(ref_b[ea+k]) << (8 * k);
                if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v -= 64'd1 << (8 * n);
                last_rd = v[31:0];
                lat = 2;
            end else begin
                for (int k = 0; k < n; k++) ref_b[ea+k] = 8'(wd >> (8 * k));
                lat = (n == 4) ? 2 : 3;
            end
            e.cyc   = cyc + lat;
            e.rd    = last_rd;
            e.mis   = mis;
            e.wes   = (we && !mis) ? 1 : 0;
            e.maddr = {a[31:2], 2'b00};
            q.push_back(e);
            mbusy = lat - 1;
        end
    endtask

    task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        while (mbusy != 0) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        step(1'b1, we, sz, uns, a, wd);
    endtask

    task automatic settle();
        while (mbusy != 0) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        bus.cpu_req      = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.cpu_size     = 2'b00;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
        ref_b[16] = 8'hBB;
        ref_b[17] = 8'hAA;
        ref_b[18] = 8'h99;
        ref_b[19] = 8'h88;

        repeat (3) @(negedge clk);
        chk("rst_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_done", 32'(bus.cpu_done), 32'h0);
        chk("rst_misalign", 32'(bus.cpu_misalign), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_busy", 32'(bus.cpu_busy), 32'h0);
        pre   = 1'b0;
        rst_n = 1'b1;

        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        settle();

        @(negedge clk);
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = 1'b1;
        bus.cpu_size     = 2'b01;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_addr     = 32'h12;
        bus.cpu_wdata    = 32'h0000CAFE;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_we_before", 32'(bus.mem_we), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_after", 32'(bus.mem_we), 32'h0);
        chk("abort_busy", 32'(bus.cpu_busy), 32'h0);
        chk("abort_done", 32'(bus.cpu_done), 32'h0);
        @(negedge clk);
        chk("abort_done_next", 32'(bus.cpu_done), 32'h0);
        chk("abort_word", dmem[4], ref_word(4));
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = 32'h0;

        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345655);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            issue(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                  {24'($urandom), 8'($urandom)}, $urandom);
        end

        settle();
        for (int i = 0; i < 4 && q.size() != 0; i++) step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("pending_done", 32'(q.size()), 32'h0);
        for (int w = 0; w < 64; w++) chk("mem_word", dmem[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
